// File: rtl/lap_timer_pkg.sv
// Shared types and constants for the lap timer: state encoding and time-field widths.
package lap_timer_pkg;

    localparam int MS_W  = 10;
    localparam int SEC_W = 6;

    localparam logic [MS_W-1:0]  MS_MAX  = 10'd999;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        MAX  = 2'd3
    } state_e;

endpackage

// File: rtl/lap_fifo.sv
// Synchronous FIFO for captured lap times; the head entry is presented combinationally (zero when empty).
module lap_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] head,
    output logic         valid,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    // A pop frees a slot in the same cycle, so push+pop while full keeps the count.
    assign do_pop  = pop && (cnt_q != '0);
    assign do_push = push && ((cnt_q != FULL_CNT) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + (AW+1)'(1);
                2'b01:   cnt_d = cnt_q - (AW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign valid = (cnt_q != '0);
    assign full  = (cnt_q == FULL_CNT);
    assign head  = valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/lap_timer.sv
// Stopwatch with ms/sec/min counters, run/hold FSM and a lap capture FIFO.
// Define LAP_TIMER_OVF_WRAP_EN to wrap to zero at maximum time instead of saturating in MAX.
module lap_timer
    import lap_timer_pkg::*;
#(
    parameter int CLK_HZ    = 16000,
    parameter int MIN_W     = 6,
    parameter int LAP_DEPTH = 4
) (
    input  logic             I_CLK,
    input  logic             I_RST,
    input  logic             I_EN,
    input  logic             I_CLR,
    input  logic             I_LAP,
    input  logic             I_LAP_RD,
    output logic [MS_W-1:0]  O_TIMER_MS,
    output logic [SEC_W-1:0] O_TIMER_SEC,
    output logic [MIN_W-1:0] O_TIMER_MIN,
    output logic [MS_W-1:0]  O_LAP_MS,
    output logic [SEC_W-1:0] O_LAP_SEC,
    output logic [MIN_W-1:0] O_LAP_MIN,
    output logic             O_LAP_VALID,
    output logic             O_LAP_FULL,
    output logic             O_OVF,
    output state_e           O_STATE
);

    localparam int PRE_DIV = CLK_HZ / 1000;
    localparam int PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_DIV - 1);
    localparam logic [MIN_W-1:0] MIN_MAX = '1;
    localparam int TIME_W = MS_W + SEC_W + MIN_W;

    state_e           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [MS_W-1:0]  ms_q, ms_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic             ovf_q, ovf_d;
    logic             count_en, tick, at_max;
    logic             lap_push, lap_pop;
    logic [TIME_W-1:0] lap_head;

    // Counting follows I_EN directly, so the cycle that enters RUN already counts
    // and every enabled cycle advances the prescaler exactly once.
    assign count_en = I_EN && !I_CLR && (state_q != MAX);
    assign tick     = count_en && (pre_q == PRE_MAX);
    assign at_max   = (ms_q == MS_MAX) && (sec_q == SEC_MAX) && (min_q == MIN_MAX);

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        ms_d    = ms_q;
        sec_d   = sec_q;
        min_d   = min_q;
        ovf_d   = ovf_q;
        if (I_CLR) begin
            state_d = IDLE;
            pre_d   = '0;
            ms_d    = '0;
            sec_d   = '0;
            min_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            if (count_en) begin
                pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PRE_W'(1);
            end
            if (tick) begin
                if (at_max) begin
                    ovf_d = 1'b1;
`ifdef LAP_TIMER_OVF_WRAP_EN
                    ms_d  = '0;
                    sec_d = '0;
                    min_d = '0;
`endif
                end else if (ms_q == MS_MAX) begin
                    ms_d = '0;
                    if (sec_q == SEC_MAX) begin
                        sec_d = '0;
                        min_d = min_q + MIN_W'(1);
                    end else begin
                        sec_d = sec_q + SEC_W'(1);
                    end
                end else begin
                    ms_d = ms_q + MS_W'(1);
                end
            end
            case (state_q)
                IDLE, HOLD, RUN: begin
                    if (I_EN) begin
                        state_d = RUN;
                    end else if (state_q == RUN) begin
                        state_d = HOLD;
                    end
                end
`ifndef LAP_TIMER_OVF_WRAP_EN
                MAX:     state_d = MAX;
`endif
                default: state_d = IDLE;
            endcase
`ifndef LAP_TIMER_OVF_WRAP_EN
            if (tick && at_max) begin
                state_d = MAX;
            end
`endif
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q <= IDLE;
            pre_q   <= '0;
            ms_q    <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            ms_q    <= ms_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            ovf_q   <= ovf_d;
        end
    end

    // Lap pulses: a push captures the time shown before the edge; a pop on an
    // empty buffer or a push on a full one without a pop has no effect.
    assign lap_push = I_LAP && !I_CLR && (state_q != IDLE);
    assign lap_pop  = I_LAP_RD && !I_CLR;

    lap_fifo #(
        .W     (TIME_W),
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk   (I_CLK),
        .rst   (I_RST),
        .clr   (I_CLR),
        .push  (lap_push),
        .pop   (lap_pop),
        .wdata ({min_q, sec_q, ms_q}),
        .head  (lap_head),
        .valid (O_LAP_VALID),
        .full  (O_LAP_FULL)
    );

    assign O_TIMER_MS  = ms_q;
    assign O_TIMER_SEC = sec_q;
    assign O_TIMER_MIN = min_q;
    assign O_LAP_MS    = lap_head[MS_W-1:0];
    assign O_LAP_SEC   = lap_head[MS_W +: SEC_W];
    assign O_LAP_MIN   = lap_head[MS_W+SEC_W +: MIN_W];
    assign O_OVF       = ovf_q;
    assign O_STATE     = state_q;

endmodule

// File: tb/tb_lap_timer.sv
// Bench for lap_timer: total-milliseconds reference model checked every cycle, plus directed literal checks.
module tb_lap_timer;
    import lap_timer_pkg::*;

    localparam int DIV   = 16;
    localparam int DEPTH = 4;
    localparam int MAXMS = 63 * 60000 + 59999;

    // clock / reset
    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    // main instance: 16 kHz, MIN_W = 6
    logic rst = 1'b1, en = 1'b0, clr = 1'b0, lap = 1'b0, lap_rd = 1'b0;
    logic [9:0] t_ms, l_ms;
    logic [5:0] t_sec, l_sec, t_min, l_min;
    logic       l_valid, l_full, ovf;
    state_e     state;

    lap_timer #(.CLK_HZ(16000), .MIN_W(6), .LAP_DEPTH(4)) dut (
        .I_CLK(clk), .I_RST(rst), .I_EN(en), .I_CLR(clr), .I_LAP(lap), .I_LAP_RD(lap_rd),
        .O_TIMER_MS(t_ms), .O_TIMER_SEC(t_sec), .O_TIMER_MIN(t_min),
        .O_LAP_MS(l_ms), .O_LAP_SEC(l_sec), .O_LAP_MIN(l_min),
        .O_LAP_VALID(l_valid), .O_LAP_FULL(l_full), .O_OVF(ovf), .O_STATE(state)
    );

    // overflow instance: 1 kHz (one ms per enabled cycle), MIN_W = 1
    logic o_rst = 1'b1, o_en = 1'b0, o_clr = 1'b0, o_lap = 1'b0, o_lap_rd = 1'b0;
    logic [9:0] o_t_ms, o_l_ms;
    logic [5:0] o_t_sec, o_l_sec;
    logic [0:0] o_t_min, o_l_min;
    logic       o_l_valid, o_l_full, o_ovf;
    state_e     o_state;

    lap_timer #(.CLK_HZ(1000), .MIN_W(1), .LAP_DEPTH(2)) dut_o (
        .I_CLK(clk), .I_RST(o_rst), .I_EN(o_en), .I_CLR(o_clr), .I_LAP(o_lap), .I_LAP_RD(o_lap_rd),
        .O_TIMER_MS(o_t_ms), .O_TIMER_SEC(o_t_sec), .O_TIMER_MIN(o_t_min),
        .O_LAP_MS(o_l_ms), .O_LAP_SEC(o_l_sec), .O_LAP_MIN(o_l_min),
        .O_LAP_VALID(o_l_valid), .O_LAP_FULL(o_l_full), .O_OVF(o_ovf), .O_STATE(o_state)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;
    bit cmp_on  = 1'b0;

    // reference model: time kept as total milliseconds, laps as a queue
    int     m_total = 0;
    int     m_sub   = 0;
    logic   m_ovf   = 1'b0;
    state_e m_state = IDLE;
    int     exp_q[$];

    always @(posedge clk) begin
        bit sat;
        sat = 1'b0;
        if (rst || clr) begin
            m_total = 0;
            m_sub   = 0;
            m_ovf   = 1'b0;
            m_state = IDLE;
            exp_q.delete();
        end else begin
            if (lap_rd && exp_q.size() > 0) void'(exp_q.pop_front());
            if (lap && m_state != IDLE && exp_q.size() < DEPTH) exp_q.push_back(m_total);
            if (en && m_state != MAX) begin
                m_sub++;
                if (m_sub == DIV) begin
                    m_sub = 0;
                    if (m_total == MAXMS) begin
                        m_ovf = 1'b1;
`ifdef LAP_TIMER_OVF_WRAP_EN
                        m_total = 0;
`else
                        sat = 1'b1;
`endif
                    end else begin
                        m_total++;
                    end
                end
            end
            if (m_state != MAX) m_state = en ? RUN : ((m_state == RUN) ? HOLD : m_state);
            if (sat) m_state = MAX;
        end
    end

    // scoreboard: every output of the main instance against the model
    always @(negedge clk) begin
        if (cmp_on) begin
            int hd;
            logic [48:0] act, exp;
            hd  = (exp_q.size() > 0) ? exp_q[0] : 0;
            exp = {10'(m_total % 1000), 6'((m_total / 1000) % 60), 6'(m_total / 60000),
                   10'(hd % 1000), 6'((hd / 1000) % 60), 6'(hd / 60000),
                   exp_q.size() > 0, exp_q.size() == DEPTH, m_ovf, m_state};
            act = {t_ms, t_sec, t_min, l_ms, l_sec, l_min, l_valid, l_full, ovf, state};
            cmp_cnt++;
            if (act !== exp) begin
                err_cnt++;
                $display("FAIL model_cmp @%0t: got %h expected %h", $time, act, exp);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input int exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_lap();
        lap = 1'b1;
        @(negedge clk);
        lap = 1'b0;
    endtask

    task automatic pulse_rd();
        lap_rd = 1'b1;
        @(negedge clk);
        lap_rd = 1'b0;
    endtask

    initial begin
        cycles(3);
        rst   = 1'b0;
        o_rst = 1'b0;
        cmp_on = 1'b1;
        check("rst_ms", 32'(t_ms), 0);
        check("rst_valid", 32'(l_valid), 0);
        check("rst_state", 32'(state), int'(IDLE));

        // one second of counting
        en = 1'b1;
        cycles(16000);
        check("one_sec_sec", 32'(t_sec), 1);
        check("one_sec_ms", 32'(t_ms), 0);
        en = 1'b0;
        cycles(1);
        check("one_sec_hold", 32'(state), int'(HOLD));
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        check("clr_sec", 32'(t_sec), 0);

        // pause/resume keeps sub-ms progress
        en = 1'b1;
        cycles(8);
        en = 1'b0;
        cycles(100);
        en = 1'b1;
        cycles(7);
        check("resume_15", 32'(t_ms), 0);
        cycles(1);
        check("resume_16", 32'(t_ms), 1);
        en = 1'b0;
        cycles(1);

        // clear dominates enable, laps ignored during clear
        en = 1'b1; clr = 1'b1; lap = 1'b1;
        cycles(3);
        check("clr_en_ms", 32'(t_ms), 0);
        check("clr_en_state", 32'(state), int'(IDLE));
        check("clr_en_valid", 32'(l_valid), 0);
        en = 1'b0; clr = 1'b0; lap = 1'b0;
        cycles(1);

        // laps every 250 ms; the fifth is dropped
        en = 1'b1;
        for (int k = 1; k <= 20001; k++) begin
            lap = (k > 1 && (k - 1) % 4000 == 0);
            @(negedge clk);
        end
        lap = 1'b0;
        check("laps_full", 32'(l_full), 1);
        check("laps_head250", 32'(l_ms), 250);
        check("laps_time_sec", 32'(t_sec), 1);
        check("laps_time_ms", 32'(t_ms), 250);
        en = 1'b0;
        pulse_rd();
        check("pop_500", 32'(l_ms), 500);
        check("pop_not_full", 32'(l_full), 0);
        pulse_rd();
        check("pop_750", 32'(l_ms), 750);
        pulse_rd();
        check("pop_1000_sec", 32'(l_sec), 1);
        check("pop_1000_ms", 32'(l_ms), 0);
        pulse_rd();
        check("pop_empty", 32'(l_valid), 0);
        pulse_rd();
        check("pop_empty_again", 32'(l_valid), 0);

        // push+pop on empty pushes only
        lap = 1'b1; lap_rd = 1'b1;
        cycles(1);
        lap = 1'b0; lap_rd = 1'b0;
        check("pp_empty_valid", 32'(l_valid), 1);
        check("pp_empty_head", 32'(l_ms), 250);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycles(16);
            pulse_lap();
        end
        check("refill_full", 32'(l_full), 1);
        lap = 1'b1; lap_rd = 1'b1;
        cycles(1);
        lap = 1'b0; lap_rd = 1'b0;
        check("pp_full_full", 32'(l_full), 1);
        check("pp_full_head", 32'(l_ms), 251);

        // reset while full and counting
        rst = 1'b1;
        cycles(1);
        rst = 1'b0; en = 1'b0;
        check("rst_full_ms", 32'(t_ms), 0);
        check("rst_full_sec", 32'(t_sec), 0);
        check("rst_full_valid", 32'(l_valid), 0);
        check("rst_full_full", 32'(l_full), 0);
        check("rst_full_lms", 32'(l_ms), 0);
        check("rst_full_state", 32'(state), int'(IDLE));
        pulse_lap();
        check("idle_lap_ignored", 32'(l_valid), 0);

        // overflow at 1:59.999 on the MIN_W = 1 instance
        o_en = 1'b1;
        cycles(3);
        o_en = 1'b0;
        check("o_ms3", 32'(o_t_ms), 3);
        cycles(1);
        force dut_o.ms_d  = 10'd999;
        force dut_o.sec_d = 6'd59;
        force dut_o.min_d = 1'b1;
        cycles(1);
        release dut_o.ms_d;
        release dut_o.sec_d;
        release dut_o.min_d;
        cycles(1);
        check("o_preload_ms", 32'(o_t_ms), 999);
        check("o_preload_ovf", 32'(o_ovf), 0);
        o_en = 1'b1;
        cycles(1);
`ifdef LAP_TIMER_OVF_WRAP_EN
        check("o_wrap_ms", 32'(o_t_ms), 0);
        check("o_wrap_sec", 32'(o_t_sec), 0);
        check("o_wrap_min", 32'(o_t_min), 0);
        check("o_wrap_state", 32'(o_state), int'(RUN));
`else
        check("o_sat_ms", 32'(o_t_ms), 999);
        check("o_sat_sec", 32'(o_t_sec), 59);
        check("o_sat_min", 32'(o_t_min), 1);
        check("o_sat_state", 32'(o_state), int'(MAX));
`endif
        check("o_ovf_set", 32'(o_ovf), 1);
        cycles(5);
        o_lap = 1'b1;
        cycles(1);
        o_lap = 1'b0;
        check("o_lap_valid", 32'(o_l_valid), 1);
`ifdef LAP_TIMER_OVF_WRAP_EN
        check("o_lap_ms", 32'(o_l_ms), 5);
`else
        check("o_sat_hold_ms", 32'(o_t_ms), 999);
        check("o_lap_ms", 32'(o_l_ms), 999);
`endif
        check("o_ovf_sticky", 32'(o_ovf), 1);
        o_clr = 1'b1;
        cycles(1);
        o_clr = 1'b0; o_en = 1'b0;
        check("o_clr_ms", 32'(o_t_ms), 0);
        check("o_clr_ovf", 32'(o_ovf), 0);
        check("o_clr_state", 32'(o_state), int'(IDLE));
        check("o_clr_valid", 32'(o_l_valid), 0);

        cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/lap_timer.md
LAP_TIMER -- requirements
Module: lap_timer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 16000, input clock frequency in Hz; SHALL be a multiple of 1000.
REQ-002 SHALL have parameter MIN_W, default 6, minute-field width in bits.
REQ-003 SHALL have parameter LAP_DEPTH, default 4, lap buffer entries, power of two, minimum 2.
REQ-004 SHALL have port I_CLK  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port I_RST  input  1  synchronous, active-high reset.
REQ-006 SHALL have port I_EN  input  1  level; 1 = count, 0 = hold.
REQ-007 SHALL have port I_CLR  input  1  level; clears time and lap buffer.
REQ-008 SHALL have port I_LAP  input  1  single-cycle pulse; capture current time.
REQ-009 SHALL have port I_LAP_RD  input  1  single-cycle pulse; pop lap head.
REQ-010 SHALL have ports O_TIMER_MS [9:0], O_TIMER_SEC [5:0] and O_TIMER_MIN [MIN_W-1:0], all outputs, carrying the live time.
REQ-011 SHALL have ports O_LAP_MS [9:0], O_LAP_SEC [5:0] and O_LAP_MIN [MIN_W-1:0], all outputs, carrying the lap buffer head.
REQ-012 SHALL have port O_LAP_VALID  output  1  lap buffer non-empty.
REQ-013 SHALL have port O_LAP_FULL  output  1  lap buffer holds LAP_DEPTH entries.
REQ-014 SHALL have port O_OVF  output  1  sticky; time reached maximum.

Function
REQ-015 SHALL implement a prescaler counting 0..CLK_HZ/1000-1; a ms tick occurs in the cycle where it equals CLK_HZ/1000-1 and the state is RUN.
REQ-016 SHALL increment ms on a tick; ms 999 -> 0 carries into sec; sec 59 -> 0 carries into min; all carries complete in the same cycle.
REQ-017 SHALL hold the prescaler value, not clear it, while I_EN=0, so pause/resume loses no sub-ms time.
REQ-018 SHALL implement the states IDLE (all zero, stopped), RUN, HOLD (stopped, nonzero) and MAX (maximum time reached).
REQ-019 SHALL make these transitions: IDLE/HOLD -> RUN on I_EN=1; RUN -> HOLD on I_EN=0; RUN -> MAX when a tick would wrap min past 2^MIN_W-1 at 59 s 999 ms.
REQ-020 SHALL give I_CLR priority over I_EN in any state: next cycle all time fields and prescaler are 0, lap buffer is empty, O_OVF=0, state is IDLE.
REQ-021 SHALL, on I_LAP in RUN or HOLD with the buffer not full, push the time value present before that clock edge.
REQ-022 SHALL drop I_LAP when the buffer is full, without corrupting the buffer, and ignore it in IDLE.
REQ-023 SHALL, on I_LAP_RD with O_LAP_VALID=1, pop the head the next cycle; I_LAP_RD when empty SHALL be ignored.
REQ-024 SHALL, on simultaneous I_LAP and I_LAP_RD while full, perform both so the count is unchanged; while empty, only the push.
REQ-025 SHALL drive O_LAP_* from the head register (zero when empty), with head data valid in the same cycle as O_LAP_VALID.
REQ-026 SHALL ignore I_LAP and I_LAP_RD in any cycle where I_CLR=1.

Reset
REQ-027 SHALL, on I_RST=1 at a clock edge, set all time outputs to 0, the prescaler to 0, O_LAP_VALID=0, O_LAP_FULL=0, O_OVF=0 and the state to IDLE; I_RST overrides every other input.
REQ-028 SHALL let reset asserted mid-count or mid-push discard all partial state; no lap entry survives reset.

Configuration
REQ-029 SHALL support macro LAP_TIMER_OVF_WRAP_EN.
REQ-030 SHALL, with LAP_TIMER_OVF_WRAP_EN defined, make the maximum tick wrap all fields to 0, set O_OVF and remain in RUN; the MAX state is not built.
REQ-031 SHALL, without LAP_TIMER_OVF_WRAP_EN, saturate at max time in state MAX with O_OVF=1, leave MAX only via I_CLR or I_RST, and still accept laps in MAX.

Structure
REQ-032 SHALL define in shared package lap_timer_pkg the state enum, the constants MS_MAX=999 and SEC_MAX=59, and the ms/sec field widths.
REQ-033 SHALL place the lap buffer in sub-module lap_fifo (sync FIFO, parametrised width and depth); counters, prescaler and FSM stay in lap_timer.

Verification
REQ-034 SHALL verify, with CLK_HZ=16000: reset, I_EN=1 for 16000 cycles -> O_TIMER_SEC=1, O_TIMER_MS=0.
REQ-035 SHALL verify: run 8 cycles, I_EN=0 for 100 cycles, then I_EN=1 for 8 cycles -> O_TIMER_MS=1 exactly.
REQ-036 SHALL verify: I_LAP at 250 ms, 500 ms, 750 ms, 1000 ms and 1250 ms -> 4 entries stored, O_LAP_FULL=1, fifth dropped, pops return 250, 500, 750 then 1000 ms.
REQ-037 SHALL verify: I_EN=1 and I_CLR=1 together -> time stays 0, state IDLE, O_LAP_VALID=0.
REQ-038 SHALL verify, with MIN_W=1: run to 1:59.999 plus 1 tick -> without the macro holds 1:59.999 with O_OVF=1; with the macro reads 0:00.000 with O_OVF=1.
REQ-039 SHALL verify: I_RST asserted while full and counting -> all outputs 0 in the next cycle.
